palette_lut_pipe: RTL and testbench

- Pipelined, run-time-programmable palette lookup for the VGA pixel path.
- Maps a compressed sprite colour index plus a palette-bank select to 12-bit RRRRGGGGBBBB.
- Flags transparent pixels to the downstream compositor.
- Sits between the sprite/map ROM readers and the VGA mixer.
- Generalises the fixed two-variant decoder to NUM_BANKS writable banks.

---
 rtl/palette_pkg.sv | 33 +++
 rtl/palette_regfile.sv | 51 +++++
 rtl/palette_lut_pipe.sv | 125 ++++++++++++
 tb/tb_palette_lut_pipe.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/palette_pkg.sv
// Shared constants, output-select encoding and default palette contents for palette_lut_pipe.
package palette_pkg;

   localparam int          RGB_W_DEF   = 12;
   localparam logic [11:0] ERR_RGB_DEF = 12'hF0F;
   localparam int          NUM_DEFS    = 11;

   localparam logic [11:0] BANK0_DEF [NUM_DEFS] = '{
      12'h000, 12'hD42, 12'h921, 12'hFF9, 12'h210, 12'h778,
      12'h6B4, 12'hDD0, 12'hFFF, 12'h0F0, 12'hBBB
   };

   localparam logic [11:0] BANK1_DEF [NUM_DEFS] = '{
      12'h000, 12'h8DF, 12'h009, 12'hFF9, 12'h210, 12'h778,
      12'h6B4, 12'hDD0, 12'hFFF, 12'h0F0, 12'hBBB
   };

   typedef enum logic [1:0] {
      SEL_ZERO,
      SEL_PAL,
      SEL_ERR,
      SEL_FLASH
   } rgb_sel_t;

   // Bank 1 has its own table; every other bank starts as a copy of bank 0.
   function automatic logic [11:0] default_entry(input int bank, input int idx,
                                                 input logic [11:0] err);
      if (idx < 0 || idx >= NUM_DEFS) return err;
      if (bank == 1) return BANK1_DEF[idx];
      return BANK0_DEF[idx];
   endfunction

endpackage

// File: rtl/palette_regfile.sv
// NUM_BANKS x 2**IDX_W palette storage: async reset to defaults, one synchronous write port,
// one registered read port that returns the pre-write value on a same-cycle collision.
module palette_regfile
   import palette_pkg::*;
#(
   parameter int               IDX_W     = 4,
   parameter int               RGB_W     = RGB_W_DEF,
   parameter int               NUM_BANKS = 2,
   parameter int               BANK_W    = 1,
   parameter logic [RGB_W-1:0] ERR_RGB   = RGB_W'(ERR_RGB_DEF)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [BANK_W-1:0] wr_bank,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [RGB_W-1:0]  wr_rgb,
   input  logic              rd_en,
   input  logic [BANK_W-1:0] rd_bank,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic [RGB_W-1:0]  rd_data
);

   localparam int DEPTH = 2 ** IDX_W;
   localparam int BI_W  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

   logic [RGB_W-1:0] mem [NUM_BANKS][DEPTH];
   logic [BI_W-1:0]  wr_bi;
   logic [BI_W-1:0]  rd_bi;
   logic             wr_ok;
   logic             rd_ok;

   assign wr_bi = wr_bank[BI_W-1:0];
   assign rd_bi = rd_bank[BI_W-1:0];
   assign wr_ok = wr_en && (int'(wr_bank) < NUM_BANKS);
   assign rd_ok = rd_en && (int'(rd_bank) < NUM_BANKS);

   // Non-blocking update means a read in the write cycle sees the old entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned b = 0; b < NUM_BANKS; b++)
            for (int unsigned i = 0; i < DEPTH; i++)
               mem[b][i] <= RGB_W'(default_entry(int'(b), int'(i), 12'(ERR_RGB)));
         rd_data <= '0;
      end else begin
         if (wr_ok) mem[wr_bi][wr_idx] <= wr_rgb;
         rd_data <= rd_ok ? mem[rd_bi][rd_idx] : '0;
      end
   end

endmodule

// File: rtl/palette_lut_pipe.sv
// Two-stage programmable palette lookup with transparency flag.
// Optional flashing-object override enabled by defining PALETTE_FLASH_EN.
module palette_lut_pipe
   import palette_pkg::*;
#(
   parameter int               IDX_W     = 4,
   parameter int               RGB_W     = RGB_W_DEF,
   parameter int               NUM_BANKS = 2,
   parameter int               BANK_W    = 1,
   parameter int               TRANS_IDX = 0,
   parameter logic [RGB_W-1:0] ERR_RGB   = RGB_W'(ERR_RGB_DEF)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [IDX_W-1:0]  in_idx,
   input  logic [BANK_W-1:0] in_bank,
   input  logic              wr_en,
   input  logic [BANK_W-1:0] wr_bank,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [RGB_W-1:0]  wr_rgb,
`ifdef PALETTE_FLASH_EN
   input  logic              frame_tick,
   input  logic              in_flash,
`endif
   output logic              out_valid,
   output logic [RGB_W-1:0]  out_rgb,
   output logic              out_transparent
);

   logic              s1_valid;
   logic [IDX_W-1:0]  s1_idx;
   logic [BANK_W-1:0] s1_bank;
   logic              s1_trans;
   logic              flash_on;
   logic              rd_en;
   logic [RGB_W-1:0]  rd_data;
   rgb_sel_t          sel_d;
   rgb_sel_t          sel_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_idx   <= '0;
         s1_bank  <= '0;
         s1_trans <= 1'b0;
      end else begin
         s1_valid <= in_valid;
         s1_idx   <= in_idx;
         s1_bank  <= in_bank;
         s1_trans <= (in_idx == IDX_W'(TRANS_IDX));
      end
   end

`ifdef PALETTE_FLASH_EN
   logic       s1_flash;
   logic [4:0] frame_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_flash  <= 1'b0;
         frame_cnt <= '0;
      end else begin
         s1_flash <= in_flash;
         if (frame_tick) frame_cnt <= frame_cnt + 5'd1;
      end
   end

   assign flash_on = frame_cnt[4] & s1_flash;
`else
   assign flash_on = 1'b0;
`endif

   // Stage 2 registers the source choice; the palette read itself is the regfile's registered port.
   always_comb begin
      sel_d = SEL_PAL;
      if (!s1_valid || s1_trans)             sel_d = SEL_ZERO;
      else if (flash_on)                     sel_d = SEL_FLASH;
      else if (int'(s1_bank) >= NUM_BANKS)   sel_d = SEL_ERR;
   end

   assign rd_en = (sel_d == SEL_PAL);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid       <= 1'b0;
         out_transparent <= 1'b0;
         sel_q           <= SEL_ZERO;
      end else begin
         out_valid       <= s1_valid;
         out_transparent <= s1_valid & s1_trans;
         sel_q           <= sel_d;
      end
   end

   always_comb begin
      out_rgb = '0;
      case (sel_q)
         SEL_PAL:   out_rgb = rd_data;
         SEL_ERR:   out_rgb = ERR_RGB;
         SEL_FLASH: out_rgb = '1;
         default:   out_rgb = '0;
      endcase
   end

   palette_regfile #(
      .IDX_W     (IDX_W),
      .RGB_W     (RGB_W),
      .NUM_BANKS (NUM_BANKS),
      .BANK_W    (BANK_W),
      .ERR_RGB   (ERR_RGB)
   ) u_regfile (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en),
      .wr_bank (wr_bank),
      .wr_idx  (wr_idx),
      .wr_rgb  (wr_rgb),
      .rd_en   (rd_en),
      .rd_bank (s1_bank),
      .rd_idx  (s1_idx),
      .rd_data (rd_data)
   );

endmodule

// File: tb/tb_palette_lut_pipe.sv
// Scoreboard bench for palette_lut_pipe: driver pushes expected pixels, monitor checks at negedge.
// Exercises the flash override too when built with PALETTE_FLASH_EN.
module tb_palette_lut_pipe;

   localparam int NB = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [3:0]  in_idx = '0;
   logic [1:0]  in_bank = '0;
   logic        wr_en = 1'b0;
   logic [1:0]  wr_bank = '0;
   logic [3:0]  wr_idx = '0;
   logic [11:0] wr_rgb = '0;
   logic        frame_tick = 1'b0;
   logic        in_flash = 1'b0;
   logic        out_valid;
   logic [11:0] out_rgb;
   logic        out_transparent;

`ifdef PALETTE_FLASH_EN
   localparam bit FLASH_EN = 1'b1;
`else
   localparam bit FLASH_EN = 1'b0;
`endif

   palette_lut_pipe #(
      .IDX_W     (4),
      .RGB_W     (12),
      .NUM_BANKS (NB),
      .BANK_W    (2),
      .TRANS_IDX (0),
      .ERR_RGB   (12'hF0F)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .in_valid        (in_valid),
      .in_idx          (in_idx),
      .in_bank         (in_bank),
      .wr_en           (wr_en),
      .wr_bank         (wr_bank),
      .wr_idx          (wr_idx),
      .wr_rgb          (wr_rgb),
`ifdef PALETTE_FLASH_EN
      .frame_tick      (frame_tick),
      .in_flash        (in_flash),
`endif
      .out_valid       (out_valid),
      .out_rgb         (out_rgb),
      .out_transparent (out_transparent)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          due;
      logic [11:0] rgb;
      logic        tr;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   ncyc  = 0;
   int   pal [NB][16];
   int   frames = 0;

   task automatic model_reset();
      int d0 [11] = '{'h000, 'hD42, 'h921, 'hFF9, 'h210, 'h778, 'h6B4, 'hDD0, 'hFFF, 'h0F0, 'hBBB};
      for (int b = 0; b < NB; b++)
         for (int i = 0; i < 16; i++)
            pal[b][i] = (i < 11) ? d0[i] : 'hF0F;
      pal[1][1] = 'h8DF;
      pal[1][2] = 'h009;
      frames = 0;
   endtask

   function automatic logic [11:0] expect_rgb(int bank, int idx, bit fl);
      if (idx == 0) return 12'h000;
      if (FLASH_EN && fl && frames >= 16) return 12'hFFF;
      if (bank >= NB) return 12'hF0F;
      return 12'(pal[bank][idx]);
   endfunction

   // One clock of stimulus; the model is updated at the same edge the DUT samples.
   task automatic step(input bit v, input int bank, input int idx,
                       input bit we, input int wb, input int wi, input int wv,
                       input bit fl, input bit tick);
      exp_t e;
      in_valid = v; in_bank = 2'(bank); in_idx = 4'(idx);
      wr_en = we; wr_bank = 2'(wb); wr_idx = 4'(wi); wr_rgb = 12'(wv);
      in_flash = fl; frame_tick = tick;
      @(posedge clk);
      if (we && wb < NB) pal[wb][wi] = wv;
      if (FLASH_EN && tick) frames = (frames + 1) % 32;
      if (v) begin
         e.due = ncyc + 2;
         e.rgb = expect_rgb(bank, idx, fl);
         e.tr  = (idx == 0);
         q.push_back(e);
      end
      #1;
   endtask

   task automatic pix(input int bank, input int idx);
      step(1'b1, bank, idx, 1'b0, 0, 0, 0, 1'b0, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
   endtask

   task automatic check_zero(input string name);
      n_cmp++;
      if (out_valid !== 1'b0 || out_rgb !== 12'h000 || out_transparent !== 1'b0) begin
         n_bad++;
         $display("FAIL %s: got v=%b rgb=%h t=%b, need v=0 rgb=000 t=0",
                  name, out_valid, out_rgb, out_transparent);
      end
   endtask

   // Monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         ncyc++;
         if (out_valid) begin
            n_cmp++;
            if (q.size() == 0) begin
               n_bad++;
               $display("FAIL stray_pixel: got rgb=%h t=%b at cycle %0d, need no output",
                        out_rgb, out_transparent, ncyc);
            end else begin
               e = q.pop_front();
               if (ncyc != e.due || out_rgb !== e.rgb || out_transparent !== e.tr) begin
                  n_bad++;
                  $display("FAIL pixel: got rgb=%h t=%b cyc=%0d, need rgb=%h t=%b cyc=%0d",
                           out_rgb, out_transparent, ncyc, e.rgb, e.tr, e.due);
               end
            end
         end else if (rst_n) begin
            n_cmp++;
            if (out_rgb !== 12'h000 || out_transparent !== 1'b0) begin
               n_bad++;
               $display("FAIL idle_out: got rgb=%h t=%b, need 000/0", out_rgb, out_transparent);
            end
            if (q.size() != 0 && q[0].due < ncyc) begin
               n_bad++;
               e = q.pop_front();
               $display("FAIL missing_pixel: got none, need rgb=%h due cyc=%0d", e.rgb, e.due);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, need finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset_state");
      rst_n = 1'b1;

      // Bank 0 sweep, then bank 1 overrides and shared entry
      for (int i = 0; i < 16; i++) pix(0, i);
      pix(1, 1); pix(1, 2); pix(1, 3);
      idle(3);

      // Read/write collision on bank 0 entry 5, then a dropped write to bank 3
      pix(0, 5);
      step(1'b1, 0, 5, 1'b1, 0, 5, 'hABC, 1'b0, 1'b0);
      pix(0, 5);
      step(1'b0, 0, 0, 1'b1, 3, 5, 'h111, 1'b0, 1'b0);
      step(1'b0, 0, 0, 1'b1, 3, 1, 'h222, 1'b0, 1'b0);
      pix(0, 5); pix(1, 5); pix(0, 1); pix(1, 1);

      // Illegal bank and transparent index
      pix(3, 4); pix(1, 0); pix(3, 0); pix(2, 9);
      idle(3);

      // Reprogram, then reset with pixels in flight
      step(1'b0, 0, 0, 1'b1, 0, 1, 'h123, 1'b0, 1'b0);
      pix(0, 1); pix(0, 1); pix(0, 2);
      rst_n = 1'b0;
      #1;
      check_zero("reset_midstream");
      q.delete();
      model_reset();
      @(posedge clk); @(posedge clk);
      #1;
      rst_n = 1'b1;
      pix(0, 1); pix(0, 5);
      idle(3);

      // Flash phase: counter sits at 16, then wraps back to 0 after 16 more ticks
      for (int i = 0; i < 16; i++) step(1'b0, 0, 0, 1'b0, 0, 0, 0, 1'b0, 1'b1);
      step(1'b1, 0, 1, 1'b0, 0, 0, 0, 1'b1, 1'b0);
      step(1'b1, 0, 1, 1'b0, 0, 0, 0, 1'b0, 1'b0);
      step(1'b1, 0, 0, 1'b0, 0, 0, 0, 1'b1, 1'b0);
      for (int i = 0; i < 16; i++) step(1'b0, 0, 0, 1'b0, 0, 0, 0, 1'b0, 1'b1);
      step(1'b1, 0, 1, 1'b0, 0, 0, 0, 1'b1, 1'b0);
      idle(3);

      // Randomised traffic with interleaved writes and frame ticks
      for (int i = 0; i < 400; i++) begin
         bit v, we, fl, tk;
         v  = ($urandom_range(0, 3) != 0);
         we = ($urandom_range(0, 3) == 0);
         fl = $urandom_range(0, 1) == 1;
         tk = ($urandom_range(0, 3) == 0);
         step(v, $urandom_range(0, 3), $urandom_range(0, 15),
              we, $urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 4095),
              fl, tk);
      end
      idle(4);

      n_cmp++;
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending pixels, need 0", q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
